// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit style
// saturating direction counters, round-robin replacement per set and a
// one-set-per-cycle invalidate sweep after reset or flush.
// Optional feature macro: BTB_STATS_EN adds saturating lookup/hit/mispredict
// statistics counters.
module btb_assoc #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8,
  parameter int WAYS    = 2,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lkp_vld,
  input  logic [ADDR_W-1:0] lkp_pc,
  output logic              pred_vld,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_vld,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lkp,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_mispr
`endif
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1'b1) << (CTR_W - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // Storage: valid bits and victim pointers are cleared by the sweep;
  // tags, targets and counters are only meaningful behind a valid bit.
  logic [WAYS-1:0]   valid_r [SETS];
  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [ADDR_W-1:0] tgt_r   [SETS][WAYS];
  logic [CTR_W-1:0]  ctr_r   [SETS][WAYS];
  logic [PTR_W-1:0]  ptr_r   [SETS];

  state_t             state_r, state_nxt;
  logic [INDEX_W-1:0] sweep_idx_r;

  logic [INDEX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0]   lkp_tag, upd_tag;
  logic               lkp_hit, upd_hit, has_free;
  logic [PTR_W-1:0]   lkp_way, upd_way, free_way, alloc_way, ptr_nxt;
  logic [CTR_W-1:0]   ctr_cur, ctr_nxt;
  logic               idle;

  assign lkp_idx = lkp_pc[INDEX_W-1:0];
  assign lkp_tag = lkp_pc[ADDR_W-1:INDEX_W];
  assign upd_idx = upd_pc[INDEX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:INDEX_W];
  assign idle    = (state_r == IDLE);
  assign busy    = (state_r == SWEEP);

  // Lookup tag compare; the lowest matching way wins.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lkp_hit && valid_r[lkp_idx][w] && (tag_r[lkp_idx][w] == lkp_tag)) begin
        lkp_hit = 1'b1;
        lkp_way = PTR_W'(w);
      end else begin
        lkp_way = lkp_way;
      end
    end
  end

  // Update-side hit detection, free-way search, victim choice and counter step.
  always_comb begin
    upd_hit  = 1'b0;
    upd_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!upd_hit && valid_r[upd_idx][w] && (tag_r[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        upd_way = PTR_W'(w);
      end else begin
        upd_way = upd_way;
      end
      if (!has_free && !valid_r[upd_idx][w]) begin
        has_free = 1'b1;
        free_way = PTR_W'(w);
      end else begin
        free_way = free_way;
      end
    end
    alloc_way = has_free ? free_way : ptr_r[upd_idx];
    if (ptr_r[upd_idx] == PTR_W'(WAYS - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = ptr_r[upd_idx] + PTR_W'(1'b1);
    end
    ctr_cur = ctr_r[upd_idx][upd_way];
    if (upd_taken) begin
      ctr_nxt = (ctr_cur == '1) ? ctr_cur : ctr_cur + CTR_W'(1'b1);
    end else begin
      ctr_nxt = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1'b1);
    end
  end

  // Sweep FSM next-state: flush restarts, last set returns to IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (flush) state_nxt = SWEEP;
        else       state_nxt = IDLE;
      end
      SWEEP: begin
        if (flush)                   state_nxt = SWEEP;
        else if (sweep_idx_r == '1)  state_nxt = IDLE;
        else                         state_nxt = SWEEP;
      end
      default: state_nxt = SWEEP;
    endcase
  end

  // Sweep FSM state register and set counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= SWEEP;
      sweep_idx_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (flush || (state_r != SWEEP)) sweep_idx_r <= '0;
      else                             sweep_idx_r <= sweep_idx_r + INDEX_W'(1'b1);
    end
  end

  // Table write port: sweep clearing has priority, updates only when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // the sweep that follows reset does the clearing
    end else if (state_r == SWEEP) begin
      valid_r[sweep_idx_r] <= '0;
      ptr_r[sweep_idx_r]   <= '0;
    end else if (upd_vld) begin
      if (upd_hit) begin
        ctr_r[upd_idx][upd_way] <= ctr_nxt;
        if (upd_taken) tgt_r[upd_idx][upd_way] <= upd_target;
      end else if (upd_taken) begin
        valid_r[upd_idx][alloc_way] <= 1'b1;
        tag_r[upd_idx][alloc_way]   <= upd_tag;
        tgt_r[upd_idx][alloc_way]   <= upd_target;
        ctr_r[upd_idx][alloc_way]   <= CTR_WEAK;
        if (!has_free) ptr_r[upd_idx] <= ptr_nxt;
      end
    end
  end

  // Registered lookup result, read from pre-update table contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_vld    <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_vld <= lkp_vld;
      if (lkp_vld && idle && lkp_hit) begin
        pred_hit    <= 1'b1;
        pred_taken  <= ctr_r[lkp_idx][lkp_way][CTR_W-1];
        pred_target <= tgt_r[lkp_idx][lkp_way];
      end else begin
        pred_hit    <= 1'b0;
        pred_taken  <= 1'b0;
        pred_target <= '0;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic              upd_pred_taken, mispr;
  logic [ADDR_W-1:0] upd_pred_tgt;
  assign upd_pred_taken = upd_hit && ctr_cur[CTR_W-1];
  assign upd_pred_tgt   = upd_hit ? tgt_r[upd_idx][upd_way] : '0;
  assign mispr          = (upd_pred_taken != upd_taken) || (upd_pred_tgt != upd_target);

  // Saturating statistics counters, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stat_lkp   <= 32'd0;
      stat_hit   <= 32'd0;
      stat_mispr <= 32'd0;
    end else begin
      if (lkp_vld && (stat_lkp != 32'hFFFF_FFFF)) stat_lkp <= stat_lkp + 32'd1;
      if (lkp_vld && idle && lkp_hit && (stat_hit != 32'hFFFF_FFFF))
        stat_hit <= stat_hit + 32'd1;
      if (upd_vld && idle && mispr && (stat_mispr != 32'hFFFF_FFFF))
        stat_mispr <= stat_mispr + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Directed, table-driven bench for btb_assoc (default parameters).
module tb_btb_assoc;
  logic        clk = 1'b0;
  logic        rst, flush, lkp_vld, upd_vld, upd_taken;
  logic [15:0] lkp_pc, upd_pc, upd_target;
  logic        pred_vld, pred_hit, pred_taken, busy;
  logic [15:0] pred_target;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lkp, stat_hit, stat_mispr;
`endif

  btb_assoc #(.ADDR_W(16), .INDEX_W(8), .WAYS(2), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lkp_vld(lkp_vld), .lkp_pc(lkp_pc),
    .pred_vld(pred_vld), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .busy(busy)
`ifdef BTB_STATS_EN
    , .stat_lkp(stat_lkp), .stat_hit(stat_hit), .stat_mispr(stat_mispr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic        lv;
    logic [15:0] lpc;
    logic        ev, eh, et;
    logic [15:0] etgt;
  } vec_t;

  vec_t tab1[17];
  vec_t tab2[15];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(input logic uv, input logic [15:0] upc, input logic ut,
                              input logic [15:0] utgt, input logic lv, input logic [15:0] lpc,
                              input logic ev, input logic eh, input logic et,
                              input logic [15:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.lv = lv; v.lpc = lpc; v.ev = ev; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic apply(input vec_t v, input string name);
    upd_vld = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
    lkp_vld = v.lv; lkp_pc = v.lpc;
    @(posedge clk); #1;
    check(name, {13'd0, pred_vld, pred_hit, pred_taken, pred_target},
          {13'd0, v.ev, v.eh, v.et, v.etgt});
    upd_vld = 1'b0; lkp_vld = 1'b0;
  endtask

  initial begin
    int n;
    logic bad;
    // update-only vectors expect pred_vld=0; lookup-only vectors carry no update
    tab1[0]  = mk(1, 16'h1234, 1, 16'h2000, 1, 16'h1234, 1, 0, 0, 16'h0000); // read-before-write
    tab1[1]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1, 1, 1, 16'h2000); // ctr 10
    tab1[2]  = mk(1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000); // 10->01
    tab1[3]  = mk(1, 16'h1234, 0, 16'h0000, 1, 16'h1234, 1, 1, 0, 16'h2000); // sees 01, ->00
    tab1[4]  = mk(1, 16'h1234, 0, 16'h0000, 1, 16'h1234, 1, 1, 0, 16'h2000); // sees 00, stays
    tab1[5]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1, 1, 0, 16'h2000); // saturated 00
    tab1[6]  = mk(1, 16'h1234, 1, 16'h3000, 1, 16'h5678, 1, 0, 0, 16'h0000); // ->01, miss elsewhere
    tab1[7]  = mk(1, 16'h1234, 1, 16'h3000, 1, 16'h1234, 1, 1, 0, 16'h3000); // sees 01, ->10
    tab1[8]  = mk(1, 16'h1234, 1, 16'h3000, 1, 16'h1234, 1, 1, 1, 16'h3000); // sees 10, ->11
    tab1[9]  = mk(1, 16'h1234, 1, 16'h3000, 1, 16'h1234, 1, 1, 1, 16'h3000); // sees 11, stays
    tab1[10] = mk(1, 16'h1234, 0, 16'h0000, 1, 16'h1234, 1, 1, 1, 16'h3000); // sees 11, ->10
    tab1[11] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1, 1, 1, 16'h3000); // 10
    tab1[12] = mk(1, 16'h0077, 0, 16'h0abc, 0, 16'h0000, 0, 0, 0, 16'h0000); // not-taken miss
    tab1[13] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0077, 1, 0, 0, 16'h0000); // nothing written
    tab1[14] = mk(1, 16'h0456, 1, 16'h0999, 1, 16'h0456, 1, 0, 0, 16'h0000); // alloc + same-cycle lookup
    tab1[15] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0456, 1, 1, 1, 16'h0999); // now hits
    tab1[16] = mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0456, 0, 0, 0, 16'h0000); // no lookup

    tab2[0]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h1100, 1, 0, 0, 16'h0000); // sweep update ignored
    tab2[1]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1, 0, 0, 16'h0000); // flushed
    tab2[2]  = mk(1, 16'h0134, 1, 16'h0a01, 0, 16'h0000, 0, 0, 0, 16'h0000); // way0
    tab2[3]  = mk(1, 16'h0234, 1, 16'h0a02, 0, 16'h0000, 0, 0, 0, 16'h0000); // way1
    tab2[4]  = mk(1, 16'h0334, 1, 16'h0a03, 0, 16'h0000, 0, 0, 0, 16'h0000); // evict way0, ptr->1
    tab2[5]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0134, 1, 0, 0, 16'h0000);
    tab2[6]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0234, 1, 1, 1, 16'h0a02);
    tab2[7]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0334, 1, 1, 1, 16'h0a03);
    tab2[8]  = mk(1, 16'h0434, 1, 16'h0a04, 0, 16'h0000, 0, 0, 0, 16'h0000); // evict way1, ptr->0
    tab2[9]  = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0234, 1, 0, 0, 16'h0000);
    tab2[10] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0334, 1, 1, 1, 16'h0a03);
    tab2[11] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0434, 1, 1, 1, 16'h0a04);
    tab2[12] = mk(1, 16'h0534, 1, 16'h0a05, 0, 16'h0000, 0, 0, 0, 16'h0000); // evict way0
    tab2[13] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0334, 1, 0, 0, 16'h0000);
    tab2[14] = mk(0, 16'h0000, 0, 16'h0000, 1, 16'h0534, 1, 1, 1, 16'h0a05);

    // reset with a lookup pending: outputs must be quiet, sweep entered
    rst = 1'b1; flush = 1'b0; upd_vld = 1'b0; upd_pc = 16'h0; upd_taken = 1'b0;
    upd_target = 16'h0; lkp_vld = 1'b1; lkp_pc = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pred", {28'd0, pred_vld, pred_hit, pred_taken, |pred_target}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);

    // count busy cycles after reset release, looking up every cycle
    rst = 1'b0; n = 0; bad = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!(pred_vld === 1'b1 && pred_hit === 1'b0)) bad = 1'b1;
    end while (busy && n < 1000);
    lkp_vld = 1'b0;
    check("reset_busy_cycles", n, 32'd256);
    check("sweep_lookup_miss", {31'd0, bad}, 32'd0);

    for (int i = 0; i < 17; i++) apply(tab1[i], $sformatf("t1[%0d]", i));

    // flush, run 10 sweep cycles, flush again: sweep restarts from set 0
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
`ifdef BTB_STATS_EN
    check("stats_cleared", stat_lkp | stat_hit | stat_mispr, 32'd0);
`endif
    upd_pc = 16'h1100; upd_taken = 1'b1; upd_target = 16'h4444; n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      upd_vld = (n == 5);
    end while (busy && n < 1000);
    upd_vld = 1'b0;
    check("reflush_busy_cycles", n, 32'd256);

    for (int i = 0; i < 15; i++) apply(tab2[i], $sformatf("t2[%0d]", i));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PC and target width in bits.
REQ-002 SHALL have parameter INDEX_W, default 8, number of sets = 2^INDEX_W.
REQ-003 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-004 SHALL have parameter CTR_W, default 2, saturating direction-counter width.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1 bit, starts an invalidate sweep.
REQ-007 SHALL have port lkp_vld, input, 1 bit, lookup request.
REQ-008 SHALL have port lkp_pc, input, ADDR_W bits, lookup PC.
REQ-009 SHALL have port pred_vld, output, 1 bit, lookup result valid.
REQ-010 SHALL have port pred_hit, output, 1 bit, tag hit.
REQ-011 SHALL have port pred_taken, output, 1 bit, hit and counter MSB is 1.
REQ-012 SHALL have port pred_target, output, ADDR_W bits, stored target.
REQ-013 SHALL have port upd_vld, input, 1 bit, resolved-branch update.
REQ-014 SHALL have port upd_pc, input, ADDR_W bits, branch PC.
REQ-015 SHALL have port upd_taken, input, 1 bit, actual direction.
REQ-016 SHALL have port upd_target, input, ADDR_W bits, actual target.
REQ-017 SHALL have port busy, output, 1 bit, high while the sweep runs.

Function
REQ-018 SHALL split PCs as follows: index = pc[INDEX_W-1:0]; tag = pc[ADDR_W-1:INDEX_W].
REQ-019 SHALL store per entry: valid, tag, target, and a CTR_W counter; SHALL store per set: a round-robin victim pointer of log2(WAYS) bits.
REQ-020 SHALL use one-cycle lookup latency: lkp_vld at edge N drives pred_vld=1 with its results during cycle N+1; pred_vld=0 otherwise.
REQ-021 SHALL resolve multiple matching ways by selecting the lowest way number.
REQ-022 SHALL force pred_hit=0, pred_taken=0, pred_target=0 on a miss.
REQ-023 SHALL make updates take effect at the edge after upd_vld; lookup and update SHALL both be accepted every cycle.
REQ-024 Update hit: taken SHALL increment the counter (saturating at all-ones) and write upd_target; not-taken SHALL decrement the counter (saturating at 0).
REQ-025 Update miss: taken SHALL allocate the first invalid way, else the pointer way, with counter = 2^(CTR_W-1) (weakly taken), and SHALL advance the pointer modulo WAYS only when a valid entry is evicted; not-taken miss SHALL write nothing.
REQ-026 On a same-cycle lookup and update to the same set, the lookup SHALL return the pre-update contents (read-before-write).
REQ-027 Sweep FSM SHALL have states IDLE and SWEEP; it SHALL enter SWEEP on rst or flush, clear valid bits and pointers for one set per cycle from set 0 to set 2^INDEX_W-1, and then return to IDLE.
REQ-028 While in SWEEP, busy SHALL be 1, lookups SHALL return pred_vld=1 with pred_hit=0, and updates SHALL be ignored.
REQ-029 flush during SWEEP SHALL restart the sweep from set 0.

Reset
REQ-030 On rst, pred_vld, pred_hit, pred_taken and pred_target SHALL be 0 at the next edge, the sweep counter SHALL be 0, and the FSM SHALL enter SWEEP; busy SHALL be 1 for exactly 2^INDEX_W cycles after rst deasserts.
REQ-031 rst asserted mid-sweep SHALL restart the sweep; counter and target storage need no reset.

Configuration
REQ-032 With BTB_STATS_EN defined, the block SHALL add outputs stat_lkp, stat_hit and stat_mispr (32 bits each, saturating), cleared by rst or flush; stat_lkp and stat_hit SHALL count accepted lookups and hits, and stat_mispr SHALL count updates where the lookup-equivalent prediction (hit, counter MSB, target) differs from (upd_taken, upd_target).
REQ-033 Without BTB_STATS_EN, the stat ports and counters SHALL be absent.

Verification
REQ-034 Release rst and count cycles -> busy=1 for 256 cycles; lookups of any PC during the sweep return pred_vld=1, pred_hit=0.
REQ-035 Update pc=0x1234, taken, target 0x2000, then lookup 0x1234 -> pred_hit=1, pred_taken=1, pred_target=0x2000 one cycle later.
REQ-036 Apply two not-taken updates to 0x1234 -> counter 10->01->00, pred_hit=1, pred_taken=0; a third not-taken update saturates at 00.
REQ-037 Taken updates to 0x0134, 0x0234 and 0x0334 (same set, WAYS=2) -> 0x0134 is evicted, the other two hit, and the pointer advances once.
REQ-038 Same-cycle lookup and allocating update of 0x0456 -> the lookup misses and the following lookup hits.
REQ-039 Assert flush after 10 cycles of a sweep -> busy stays high for 256 further cycles; with BTB_STATS_EN, the stats read 0 after the flush.
